// File: rtl/vend_sequencer.sv
// vend_sequencer: main sequencing FSM of the vending machine.
// Takes coins, accumulates credit, grants a vend once the price is covered,
// times the dispense pulse and pays change or refunds one nickel per cycle.
//
// Optional feature: define VEND_TIMEOUT_EN to refund automatically after
// TIMEOUT_CYCLES cycles of inactivity in CREDIT/PAID.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no credit, waiting for the first coin
// CREDIT   | credit below price, more coins expected
// PAID     | credit covers price, vend or more coins possible
// DISPENSE | motor driven for DISPENSE_CYCLES cycles
// CHANGE   | paying the remainder after a vend, one nickel per cycle
// REFUND   | returning the whole credit after cancel/timeout
// 6..15    | unreachable; recover to IDLE and drop credit

module vend_sequencer #(
    parameter int PRICE           = 75,
    parameter int MAX_CREDIT      = 255,
    parameter int DISPENSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_value_i,
    input  logic       cancel_i,
    input  logic       vend_req_i,
    input  logic       item_ready_i,
    output logic       coin_accept_o,
    output logic       coin_reject_o,
    output logic       sold_out_o,
    output logic       dispense_o,
    output logic       change_pulse_o,
    output logic [7:0] credit_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CREDIT   = 4'd1,
        ST_PAID     = 4'd2,
        ST_DISPENSE = 4'd3,
        ST_CHANGE   = 4'd4,
        ST_REFUND   = 4'd5
    } state_e;

    // dispense timer holds DISPENSE_CYCLES-1 down to 0
    localparam int DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    state_e         state_q, state_d;
    logic [7:0]     credit_q, credit_d;
    logic [DW-1:0]  disp_cnt_q, disp_cnt_d;
    logic           coin_accept_q, coin_accept_d;
    logic           coin_reject_q, coin_reject_d;
    logic           sold_out_q, sold_out_d;
    logic           dispense_q, dispense_d;
    logic           change_q, change_d;

    logic [8:0]     coin_val;
    logic [8:0]     coin_sum;
    logic           coin_ok;
    logic           in_purchase;
    logic           vend_grant;
    logic           tmo_hit;

    // coin value in cents; slug contributes nothing and is never accepted
    always_comb begin
        coin_val = 9'd0;
        case (coin_value_i)
            2'b00:   coin_val = 9'd5;
            2'b01:   coin_val = 9'd10;
            2'b10:   coin_val = 9'd25;
            default: coin_val = 9'd0;
        endcase
    end

    assign coin_sum    = {1'b0, credit_q} + coin_val;
    assign coin_ok     = coin_valid_i && (coin_value_i != 2'b11)
                         && (coin_sum <= 9'(MAX_CREDIT));
    assign in_purchase = (state_q == ST_CREDIT) || (state_q == ST_PAID);
    assign vend_grant  = (state_q == ST_PAID) && vend_req_i && item_ready_i;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // inactivity down-counter, reloaded on entry to CREDIT/PAID and on each accepted coin
    always_comb begin
        tmo_d = tmo_q;
        if (coin_accept_d ||
            (((state_d == ST_CREDIT) || (state_d == ST_PAID)) && !in_purchase)) begin
            tmo_d = TW'(TIMEOUT_CYCLES - 1);
        end else if (in_purchase && (tmo_q != '0)) begin
            tmo_d = tmo_q - TW'(1);
        end
    end

    // inactivity counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = in_purchase && (tmo_q == '0);
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
`endif

    // next-state, credit and output decode; priority cancel > vend > coin > timeout
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_cnt_d    = disp_cnt_q;
        coin_accept_d = 1'b0;
        sold_out_d    = 1'b0;
        dispense_d    = 1'b0;
        change_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT, ST_PAID: begin
                if (cancel_i && in_purchase) begin
                    state_d  = ST_REFUND;
                    change_d = (credit_q != 8'd0);
                end else if (vend_grant) begin
                    state_d    = ST_DISPENSE;
                    credit_d   = credit_q - 8'(PRICE);
                    dispense_d = 1'b1;
                    disp_cnt_d = DW'(DISPENSE_CYCLES - 1);
                end else begin
                    if ((state_q == ST_PAID) && vend_req_i) begin
                        sold_out_d = 1'b1;
                    end
                    // a coin alongside cancel is returned even where cancel itself has no effect
                    if (coin_ok && !cancel_i) begin
                        coin_accept_d = 1'b1;
                        credit_d      = coin_sum[7:0];
                        state_d       = (coin_sum >= 9'(PRICE)) ? ST_PAID : ST_CREDIT;
                    end else if (tmo_hit) begin
                        state_d  = ST_REFUND;
                        change_d = (credit_q != 8'd0);
                    end
                end
            end

            ST_DISPENSE: begin
                if (disp_cnt_q == '0) begin
                    state_d  = (credit_q != 8'd0) ? ST_CHANGE : ST_IDLE;
                    change_d = (credit_q != 8'd0);
                end else begin
                    disp_cnt_d = disp_cnt_q - DW'(1);
                    dispense_d = 1'b1;
                end
            end

            ST_CHANGE, ST_REFUND: begin
                // the nickel shown this cycle is deducted at its end
                if (credit_q <= 8'd5) begin
                    credit_d = 8'd0;
                    state_d  = ST_IDLE;
                end else begin
                    credit_d = credit_q - 8'd5;
                    change_d = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                credit_d = 8'd0;
            end
        endcase

        coin_reject_d = coin_valid_i && !coin_accept_d;
    end

    // state, credit and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= 8'd0;
            disp_cnt_q    <= '0;
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            sold_out_q    <= 1'b0;
            dispense_q    <= 1'b0;
            change_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_cnt_q    <= disp_cnt_d;
            coin_accept_q <= coin_accept_d;
            coin_reject_q <= coin_reject_d;
            sold_out_q    <= sold_out_d;
            dispense_q    <= dispense_d;
            change_q      <= change_d;
        end
    end

    assign coin_accept_o  = coin_accept_q;
    assign coin_reject_o  = coin_reject_q;
    assign sold_out_o     = sold_out_q;
    assign dispense_o     = dispense_q;
    assign change_pulse_o = change_q;
    assign credit_o       = credit_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with hand-computed expectations.
// Build with +define+VEND_TIMEOUT_EN to exercise the inactivity refund.

module tb_vend_sequencer;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       cancel;
    logic       vend_req;
    logic       item_ready;
    logic       coin_accept;
    logic       coin_reject;
    logic       sold_out;
    logic       dispense;
    logic       change_pulse;
    logic [7:0] credit;
    logic [3:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    vend_sequencer #(
        .PRICE          (75),
        .MAX_CREDIT     (255),
        .DISPENSE_CYCLES(4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_valid_i  (coin_valid),
        .coin_value_i  (coin_value),
        .cancel_i      (cancel),
        .vend_req_i    (vend_req),
        .item_ready_i  (item_ready),
        .coin_accept_o (coin_accept),
        .coin_reject_o (coin_reject),
        .sold_out_o    (sold_out),
        .dispense_o    (dispense),
        .change_pulse_o(change_pulse),
        .credit_o      (credit),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
    endtask

    // count change pulses until the FSM returns to IDLE (bounded)
    task automatic drain(input string tag, input int exp_pulses);
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        while (state != 4'd0 && cyc < 300) begin
            if (change_pulse) n++;
            step();
            cyc++;
        end
        chk({tag, "_pulses"}, 32'(n), 32'(exp_pulses));
        chk({tag, "_idle"}, 32'(state), 32'd0);
        chk({tag, "_credit"}, 32'(credit), 32'd0);
    endtask

    task automatic refund(input string tag, input int exp_pulses);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk({tag, "_state"}, 32'(state), 32'd5);
        drain(tag, exp_pulses);
    endtask

    initial begin
        rst_n      = 1'b0;
        coin_valid = 1'b0;
        coin_value = 2'b00;
        cancel     = 1'b0;
        vend_req   = 1'b0;
        item_ready = 1'b1;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_accept", 32'(coin_accept), 32'd0);
        chk("rst_reject", 32'(coin_reject), 32'd0);
        chk("rst_sold", 32'(sold_out), 32'd0);
        chk("rst_disp", 32'(dispense), 32'd0);
        chk("rst_chg", 32'(change_pulse), 32'd0);
        rst_n = 1'b1;
        step();

        // three quarters on consecutive cycles
        coin_valid = 1'b1;
        coin_value = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("q3_accept", 32'(coin_accept), 32'd1);
            chk("q3_credit", 32'(credit), 32'(25 * i));
            chk("q3_state", 32'(state), (i == 3) ? 32'd2 : 32'd1);
        end
        coin_valid = 1'b0;

        // exact-price vend: four dispense cycles, no change
        vend_req = 1'b1;
        step();
        vend_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("v75_disp", 32'(dispense), 32'd1);
            chk("v75_state", 32'(state), 32'd3);
            chk("v75_credit", 32'(credit), 32'd0);
            step();
        end
        chk("v75_disp_off", 32'(dispense), 32'd0);
        chk("v75_idle", 32'(state), 32'd0);
        chk("v75_nochg", 32'(change_pulse), 32'd0);

        // 100 cents then vend: 25 cents change in five pulses
        coin_valid = 1'b1;
        coin_value = 2'b10;
        repeat (4) step();
        coin_valid = 1'b0;
        chk("c100_credit", 32'(credit), 32'd100);
        vend_req = 1'b1;
        step();
        vend_req = 1'b0;
        chk("c100_credit_after", 32'(credit), 32'd25);
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            chk("chg_state", 32'(state), 32'd4);
            chk("chg_pulse", 32'(change_pulse), 32'd1);
            chk("chg_credit", 32'(credit), 32'(25 - 5 * i));
            step();
        end
        chk("chg_idle", 32'(state), 32'd0);
        chk("chg_credit0", 32'(credit), 32'd0);
        chk("chg_off", 32'(change_pulse), 32'd0);

        // credit 35, cancel together with a dime
        insert(2'b10);
        insert(2'b01);
        chk("c35_credit", 32'(credit), 32'd35);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = 2'b01;
        step();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        chk("cxl_reject", 32'(coin_reject), 32'd1);
        chk("cxl_accept", 32'(coin_accept), 32'd0);
        chk("cxl_state", 32'(state), 32'd5);
        chk("cxl_credit", 32'(credit), 32'd35);
        drain("cxl", 7);

        // credit ceiling: 250 then dime rejected, nickel reaches 255
        coin_valid = 1'b1;
        coin_value = 2'b10;
        repeat (10) step();
        coin_valid = 1'b0;
        chk("c250_credit", 32'(credit), 32'd250);
        chk("c250_state", 32'(state), 32'd2);
        insert(2'b01);
        chk("max_reject", 32'(coin_reject), 32'd1);
        chk("max_credit", 32'(credit), 32'd250);
        insert(2'b00);
        chk("max_nickel_acc", 32'(coin_accept), 32'd1);
        chk("max_nickel_cr", 32'(credit), 32'd255);
        refund("rf255", 51);

        // slug in IDLE
        insert(2'b11);
        chk("slug_reject", 32'(coin_reject), 32'd1);
        chk("slug_accept", 32'(coin_accept), 32'd0);
        chk("slug_state", 32'(state), 32'd0);

        // vend refused for empty slot
        coin_valid = 1'b1;
        coin_value = 2'b10;
        repeat (3) step();
        coin_valid = 1'b0;
        item_ready = 1'b0;
        vend_req   = 1'b1;
        step();
        vend_req   = 1'b0;
        item_ready = 1'b1;
        chk("so_pulse", 32'(sold_out), 32'd1);
        chk("so_state", 32'(state), 32'd2);
        chk("so_disp", 32'(dispense), 32'd0);
        chk("so_credit", 32'(credit), 32'd75);
        step();
        chk("so_once", 32'(sold_out), 32'd0);
        refund("rf75", 15);

        // coin during dispense is returned; async reset aborts mid-dispense
        coin_valid = 1'b1;
        coin_value = 2'b10;
        repeat (3) step();
        coin_valid = 1'b0;
        vend_req   = 1'b1;
        step();
        vend_req   = 1'b0;
        insert(2'b00);
        chk("disp_coin_rej", 32'(coin_reject), 32'd1);
        chk("disp_coin_cr", 32'(credit), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_disp", 32'(dispense), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // single nickel followed by inactivity
        insert(2'b00);
        chk("tmo_entry", 32'(state), 32'd1);
`ifdef VEND_TIMEOUT_EN
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("tmo_wait", 32'(state), 32'd1);
        end
        step();
        chk("tmo_refund", 32'(state), 32'd5);
        chk("tmo_pulse", 32'(change_pulse), 32'd1);
        chk("tmo_credit", 32'(credit), 32'd5);
        step();
        chk("tmo_idle", 32'(state), 32'd0);
        chk("tmo_credit0", 32'(credit), 32'd0);
`else
        repeat (100) step();
        chk("hold_state", 32'(state), 32'd1);
        chk("hold_credit", 32'(credit), 32'd5);
        refund("rf5", 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
